// File: rtl/rtc_pkg.sv
// Shared constants and types for the RTC time-edit controller.
// Field order is sec, min, hour, date, month, week, year.
package rtc_pkg;

  localparam int F_SEC   = 0;
  localparam int F_MIN   = 1;
  localparam int F_HOUR  = 2;
  localparam int F_DATE  = 3;
  localparam int F_MONTH = 4;
  localparam int F_WEEK  = 5;
  localparam int F_YEAR  = 6;

  // Entry i is the BCD limit of field i.
  localparam logic [6:0][7:0] BCD_MIN = {
    8'h00, 8'h01, 8'h01, 8'h01, 8'h00, 8'h00, 8'h00
  };
  localparam logic [6:0][7:0] BCD_MAX = {
    8'h99, 8'h07, 8'h12, 8'h31, 8'h23, 8'h59, 8'h59
  };

  typedef enum logic [1:0] {
    IDLE,
    EDIT,
    COMMIT
  } state_e;

  function automatic int clog2(input longint v);
    int     r;
    longint x;
    r = 0;
    x = v - 1;
    while (x > 0) begin
      r++;
      x = x >> 1;
    end
    if (r < 1) r = 1;
    return r;
  endfunction

endpackage

// File: rtl/bcd_step.sv
// One BCD up/down step with field-limit wrap.
// Invalid or out-of-range inputs snap to the field minimum.
module bcd_step
  import rtc_pkg::*;
(
  input  logic [7:0] value,
  input  logic [7:0] min,
  input  logic [7:0] max,
  input  logic       dir,
  output logic [7:0] nxt
);

  logic ok;

  assign ok = (value[7:4] <= 4'd9) && (value[3:0] <= 4'd9) &&
              (value >= min) && (value <= max);

  always_comb begin
    nxt = min;
    if (!ok) begin
      nxt = min;
    end else if (!dir) begin
      if (value == max)
        nxt = min;
      else if (value[3:0] == 4'd9)
        nxt = {value[7:4] + 4'd1, 4'd0};
      else
        nxt = value + 8'd1;
    end else begin
      if (value == min)
        nxt = max;
      else if (value[3:0] == 4'd0)
        nxt = {value[7:4] - 4'd1, 4'd9};
      else
        nxt = value - 8'd1;
    end
  end

endmodule

// File: rtl/rtc_edit_ctrl.sv
// Key-driven edit of a BCD time snapshot with commit strobe,
// selected-field blink mask and inactivity timeout.
module rtc_edit_ctrl
  import rtc_pkg::*;
#(
  parameter int NUM_FIELDS = 3,
  parameter int CLK_HZ     = 50_000_000,
  parameter int BLINK_HZ   = 2,
  parameter int TIMEOUT_S  = 10
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    key_sel,
  input  logic                    key_inc,
  input  logic                    key_dec,
  input  logic                    key_ok,
  input  logic                    key_esc,
  input  logic [8*NUM_FIELDS-1:0] read_time,
  output logic [8*NUM_FIELDS-1:0] disp_time,
  output logic [8*NUM_FIELDS-1:0] write_time,
  output logic                    write_req,
  output logic                    edit_active,
  output logic [2:0]              edit_field,
  output logic [NUM_FIELDS-1:0]   blink_mask
);

  localparam int     W       = 8 * NUM_FIELDS;
  localparam longint TO_CYC  = longint'(TIMEOUT_S) * longint'(CLK_HZ);
  localparam longint HALF_RW = longint'(CLK_HZ) / (2 * longint'(BLINK_HZ));
  localparam longint HALF    = (HALF_RW < 1) ? 1 : HALF_RW;
  localparam int     TO_W    = clog2(TO_CYC);
  localparam int     BL_W    = clog2(HALF);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TO_CYC - 1);
  localparam logic [BL_W-1:0] BL_LAST = BL_W'(HALF - 1);
  localparam logic [2:0]      F_LAST  = 3'(NUM_FIELDS - 1);

  state_e          state_q, state_d;
  logic [W-1:0]    buf_q, buf_d;
  logic [W-1:0]    disp_q, disp_d;
  logic [W-1:0]    wt_q, wt_d;
  logic            wr_q, wr_d;
  logic            act_q, act_d;
  logic [2:0]      field_q, field_d;
  logic [TO_W-1:0] to_q, to_d;
  logic [BL_W-1:0] bl_q, bl_d;
  logic            ph_q, ph_d;

  logic [7:0] cur;
  logic [7:0] stepped;
  logic       key_any;

  assign cur     = buf_q[8*int'(field_q) +: 8];
  assign key_any = key_ok | key_esc | key_sel | key_inc | key_dec;

  bcd_step u_step (
    .value (cur),
    .min   (BCD_MIN[field_q]),
    .max   (BCD_MAX[field_q]),
    .dir   (~key_inc),
    .nxt   (stepped)
  );

  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    disp_d  = disp_q;
    wt_d    = wt_q;
    field_d = field_q;
    to_d    = '0;
    bl_d    = '0;
    ph_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        disp_d = read_time;
        if (key_sel) begin
          buf_d   = read_time;
          field_d = 3'd0;
          state_d = EDIT;
        end
      end
      EDIT: begin
        to_d = to_q + 1'b1;
        if (bl_q == BL_LAST) begin
          bl_d = '0;
          ph_d = ~ph_q;
        end else begin
          bl_d = bl_q + 1'b1;
          ph_d = ph_q;
        end
        if (key_any) begin
          to_d = '0;
          bl_d = '0;
          ph_d = 1'b0;
        end
        // Any key outranks a timeout landing on the same edge.
        priority case (1'b1)
          key_ok: begin
            wt_d    = buf_q;
            state_d = COMMIT;
          end
          key_esc: state_d = IDLE;
          key_sel: field_d = (field_q == F_LAST) ? 3'd0 : field_q + 3'd1;
          key_inc,
          key_dec: buf_d[8*int'(field_q) +: 8] = stepped;
          default: if (to_q == TO_LAST) state_d = IDLE;
        endcase
        disp_d = buf_d;
      end
      COMMIT: begin
        disp_d  = buf_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (state_d != EDIT) begin
      to_d = '0;
      bl_d = '0;
      ph_d = 1'b0;
    end
    act_d = (state_d == EDIT);
    wr_d  = (state_d == COMMIT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      buf_q   <= '0;
      disp_q  <= '0;
      wt_q    <= '0;
      wr_q    <= 1'b0;
      act_q   <= 1'b0;
      field_q <= 3'd0;
      to_q    <= '0;
      bl_q    <= '0;
      ph_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      disp_q  <= disp_d;
      wt_q    <= wt_d;
      wr_q    <= wr_d;
      act_q   <= act_d;
      field_q <= field_d;
      to_q    <= to_d;
      bl_q    <= bl_d;
      ph_q    <= ph_d;
    end
  end

  assign disp_time   = disp_q;
  assign write_time  = wt_q;
  assign write_req   = wr_q;
  assign edit_active = act_q;
  assign edit_field  = field_q;
  assign blink_mask  = (act_q && ph_q) ?
                       (NUM_FIELDS'(1) << field_q) : '0;

endmodule

// File: tb/tb_rtc_edit_ctrl.sv
// Directed bench for rtc_edit_ctrl, 3-field and 7-field builds,
// with write strobes checked against queued expected commits.
module tb_rtc_edit_ctrl;

  localparam logic [4:0] K_OK  = 5'b10000;
  localparam logic [4:0] K_ESC = 5'b01000;
  localparam logic [4:0] K_SEL = 5'b00100;
  localparam logic [4:0] K_INC = 5'b00010;
  localparam logic [4:0] K_DEC = 5'b00001;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  k3, k7;
  logic [23:0] rt3, disp3, wt3;
  logic [55:0] rt7, disp7, wt7;
  logic        wr3, wr7, act3, act7;
  logic [2:0]  fld3, fld7;
  logic [2:0]  bm3;
  logic [6:0]  bm7;

  int n_cmp = 0;
  int n_bad = 0;

  logic [23:0] q3[$];
  logic [55:0] q7[$];

  always #5 clk = ~clk;

  rtc_edit_ctrl #(
    .NUM_FIELDS(3), .CLK_HZ(1000), .BLINK_HZ(2), .TIMEOUT_S(1)
  ) u3 (
    .clk(clk), .rst_n(rst_n),
    .key_sel(k3[2]), .key_inc(k3[1]), .key_dec(k3[0]),
    .key_ok(k3[4]), .key_esc(k3[3]),
    .read_time(rt3), .disp_time(disp3), .write_time(wt3),
    .write_req(wr3), .edit_active(act3), .edit_field(fld3),
    .blink_mask(bm3)
  );

  rtc_edit_ctrl #(
    .NUM_FIELDS(7), .CLK_HZ(1000), .BLINK_HZ(2), .TIMEOUT_S(1)
  ) u7 (
    .clk(clk), .rst_n(rst_n),
    .key_sel(k7[2]), .key_inc(k7[1]), .key_dec(k7[0]),
    .key_ok(k7[4]), .key_esc(k7[3]),
    .read_time(rt7), .disp_time(disp7), .write_time(wt7),
    .write_req(wr7), .edit_active(act7), .edit_field(fld7),
    .blink_mask(bm7)
  );

  // Scoreboard monitors: every strobe must match a queued commit.
  always @(negedge clk) begin
    if (wr3) begin
      n_cmp++;
      if (q3.size() == 0) begin
        n_bad++;
        $display("FAIL wr3_unexpected: write_time=%h, no commit queued", wt3);
      end else begin
        logic [23:0] e;
        e = q3.pop_front();
        if (wt3 !== e) begin
          n_bad++;
          $display("FAIL wr3_data: got %h exp %h", wt3, e);
        end
      end
    end
    if (wr7) begin
      n_cmp++;
      if (q7.size() == 0) begin
        n_bad++;
        $display("FAIL wr7_unexpected: write_time=%h, no commit queued", wt7);
      end else begin
        logic [55:0] e;
        e = q7.pop_front();
        if (wt7 !== e) begin
          n_bad++;
          $display("FAIL wr7_data: got %h exp %h", wt7, e);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] got,
                     input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h exp %h", nm, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press3(input logic [4:0] k);
    k3 = k;
    tick();
    k3 = '0;
  endtask

  task automatic press7(input logic [4:0] k);
    k7 = k;
    tick();
    k7 = '0;
  endtask

  initial begin
    rst_n = 1'b0;
    k3 = '0;
    k7 = '0;
    rt3 = 24'h180250;
    rt7 = 56'h24_07_01_31_12_00_00;
    #12;
    chk("rst_disp", 64'(disp3), 64'h0);
    chk("rst_wt", 64'(wt3), 64'h0);
    chk("rst_wr", 64'(wr3), 64'h0);
    chk("rst_act", 64'(act3), 64'h0);
    chk("rst_fld", 64'(fld3), 64'h0);
    chk("rst_bm", 64'(bm3), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    tick();
    chk("idle_pass", 64'(disp3), 64'h180250);
    press3(K_INC);
    chk("idle_ignore_inc", 64'(act3), 64'h0);

    press3(K_SEL);
    chk("enter_act", 64'(act3), 64'h1);
    chk("enter_fld", 64'(fld3), 64'h0);
    rt3 = 24'h000000;
    tick();
    chk("snapshot", 64'(disp3), 64'h180250);
    repeat (9) press3(K_INC);
    chk("sec_59", 64'(disp3), 64'h180259);
    press3(K_INC);
    chk("sec_wrap", 64'(disp3), 64'h180200);
    q3.push_back(24'h180200);
    press3(K_OK);
    chk("ok_act", 64'(act3), 64'h0);
    chk("ok_wr", 64'(wr3), 64'h1);
    tick();
    chk("ok_wr_1cyc", 64'(wr3), 64'h0);
    chk("ok_wt_hold", 64'(wt3), 64'h180200);

    rt3 = 24'h230959;
    press3(K_SEL);
    press3(K_SEL);
    press3(K_SEL);
    chk("fld_hour", 64'(fld3), 64'h2);
    press3(K_INC);
    chk("hour_inc", 64'(disp3), 64'h000959);
    press3(K_DEC);
    chk("hour_dec", 64'(disp3), 64'h230959);
    press3(K_SEL);
    chk("fld_wrap", 64'(fld3), 64'h0);
    press3(K_SEL);
    press3(K_INC);
    chk("min_inc", 64'(disp3), 64'h231059);
    press3(K_DEC);
    chk("min_dec", 64'(disp3), 64'h230959);
    q3.push_back(24'h230959);
    press3(K_OK | K_INC);
    chk("ok_inc_act", 64'(act3), 64'h0);
    tick();

    press3(K_SEL);
    press3(K_INC);
    chk("esc_pre", 64'(disp3), 64'h230900);
    press3(K_ESC);
    chk("esc_act", 64'(act3), 64'h0);
    chk("esc_wr", 64'(wr3), 64'h0);
    chk("esc_wt", 64'(wt3), 64'h230959);

    rt3 = 24'h3F0000;
    tick();
    press3(K_SEL);
    press3(K_SEL);
    press3(K_SEL);
    press3(K_INC);
    chk("clamp", 64'(disp3), 64'h000000);
    press3(K_ESC);

    press3(K_SEL);
    chk("bm_enter", 64'(bm3), 64'h0);
    repeat (249) tick();
    chk("bm_pre", 64'(bm3), 64'h0);
    tick();
    chk("bm_f0", 64'(bm3), 64'h1);
    press3(K_SEL);
    chk("bm_key_clr", 64'(bm3), 64'h0);
    repeat (250) tick();
    chk("bm_f1", 64'(bm3), 64'h2);
    press3(K_SEL);
    repeat (250) tick();
    chk("bm_f2", 64'(bm3), 64'h4);
    press3(K_SEL);
    repeat (250) tick();
    chk("bm_f0_wrap", 64'(bm3), 64'h1);
    press3(K_ESC);
    chk("bm_idle", 64'(bm3), 64'h0);

    press3(K_SEL);
    repeat (999) tick();
    chk("to_999", 64'(act3), 64'h1);
    tick();
    chk("to_1000", 64'(act3), 64'h0);

    press3(K_SEL);
    repeat (998) tick();
    press3(K_SEL);
    chk("to_restart", 64'(act3), 64'h1);
    repeat (999) tick();
    chk("to_restart_999", 64'(act3), 64'h1);
    tick();
    chk("to_restart_1000", 64'(act3), 64'h0);

    press3(K_SEL);
    press3(K_SEL);
    press3(K_INC);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_act", 64'(act3), 64'h0);
    chk("arst_fld", 64'(fld3), 64'h0);
    chk("arst_wt", 64'(wt3), 64'h0);
    chk("arst_disp", 64'(disp3), 64'h0);
    chk("arst_wr", 64'(wr3), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) tick();
    chk("arst_after_wr", 64'(wr3), 64'h0);
    chk("arst_after_act", 64'(act3), 64'h0);

    press7(K_SEL);
    press7(K_SEL);
    press7(K_SEL);
    press7(K_SEL);
    chk("f7_fld_date", 64'(fld7), 64'h3);
    press7(K_INC);
    chk("f7_date", 64'(disp7), 64'h24_07_01_01_12_00_00);
    press7(K_SEL);
    press7(K_DEC);
    chk("f7_month", 64'(disp7), 64'h24_07_12_01_12_00_00);
    press7(K_SEL);
    press7(K_INC);
    chk("f7_week", 64'(disp7), 64'h24_01_12_01_12_00_00);
    q7.push_back(56'h24_01_12_01_12_00_00);
    press7(K_OK);
    repeat (3) tick();
    chk("f7_wt", 64'(wt7), 64'h24_01_12_01_12_00_00);

    chk("q3_drained", 64'(q3.size()), 64'h0);
    chk("q7_drained", 64'(q7.size()), 64'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
